// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen register bus blocks: response status codes,
// the bus arbiter state encoding and a small width helper.
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_OKAY   = 2'b00,
    RGGEN_EXOKAY = 2'b01,
    RGGEN_SLVERR = 2'b10,
    RGGEN_DECERR = 2'b11
  } rggen_status;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } rggen_bus_arbiter_state;

  // Index width for a vector of n entries; never narrower than one bit so a
  // single-entry vector still gets a legal (constant zero) index register.
  function automatic int rggen_index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rggen_round_robin_select.sv
// Combinational round-robin picker: scans the request vector starting at
// the pointer position, wrapping around, and returns the first set entry as
// a one-hot grant plus its binary index.
module rggen_round_robin_select
  import rggen_rtl_pkg::*;
#(
  parameter int WIDTH = 2,
  localparam int INDEX_WIDTH = rggen_index_width(WIDTH)
) (
  input  logic [WIDTH-1:0]       request,
  input  logic [INDEX_WIDTH-1:0] pointer,
  output logic [WIDTH-1:0]       grant,
  output logic [INDEX_WIDTH-1:0] index,
  output logic                   found
);

  // Priority scan from pointer upward; the first hit locks out the rest.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    grant = '0;
    index = '0;
    found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      int k;
      k = (int'(pointer) + i) % WIDTH;
      if (!found && request[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        index    = INDEX_WIDTH'(k);
      end
    end
  end

endmodule

// File: rtl/rggen_register_bus_arbiter.sv
// Shares one rggen register bus between REQUESTERS hosts. A round-robin
// winner is chosen in IDLE, its request is latched and driven downstream
// until ready (or until the optional timeout fires), and the response is
// returned to that host alone as a one-cycle ack.
module rggen_register_bus_arbiter
  import rggen_rtl_pkg::*;
#(
  parameter int REQUESTERS     = 2,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic [REQUESTERS-1:0]                i_req_valid,
  input  logic [REQUESTERS-1:0]                i_req_write,
  input  logic [REQUESTERS*ADDRESS_WIDTH-1:0]  i_req_address,
  input  logic [REQUESTERS*BUS_WIDTH-1:0]      i_req_write_data,
  input  logic [REQUESTERS*BUS_WIDTH/8-1:0]    i_req_strobe,
  output logic [REQUESTERS-1:0]                o_req_ack,
  output logic [1:0]                           o_req_status,
  output logic [BUS_WIDTH-1:0]                 o_req_read_data,
  output logic                                 o_valid,
  output logic                                 o_write,
  output logic [ADDRESS_WIDTH-1:0]             o_address,
  output logic [BUS_WIDTH-1:0]                 o_write_data,
  output logic [BUS_WIDTH/8-1:0]               o_strobe,
  input  logic                                 i_ready,
  input  logic [1:0]                           i_status,
  input  logic [BUS_WIDTH-1:0]                 i_read_data,
  output logic [REQUESTERS-1:0]                o_grant
);

  localparam int PW = rggen_index_width(REQUESTERS);
  localparam int SW = BUS_WIDTH / 8;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  rggen_bus_arbiter_state state;
  logic [PW-1:0]          pointer;
  logic [PW-1:0]          grant_index;
  logic [TW-1:0]          timer;
  rggen_status            status;

  logic [REQUESTERS-1:0]  rr_grant;
  logic [PW-1:0]          rr_index;
  logic                   rr_found;
  logic                   timeout_hit;
  logic                   finish;

  // The host being acked this cycle still holds valid; mask it so it
  // cannot win again before it has seen its ack.
  rggen_round_robin_select #(
    .WIDTH (REQUESTERS)
  ) u_select (
    .request (i_req_valid & ~o_req_ack),
    .pointer (pointer),
    .grant   (rr_grant),
    .index   (rr_index),
    .found   (rr_found)
  );

  // The limit counts the current BUSY cycle, so it trips with the timer
  // one below TIMEOUT_CYCLES; a zero limit never trips.
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (timer == TW'(TIMEOUT_CYCLES - 1));
  assign finish      = (state == BUSY) && (i_ready || timeout_hit);
  assign o_req_status = status;

  function automatic logic [PW-1:0] next_pointer(input logic [PW-1:0] idx);
    return (idx == PW'(REQUESTERS - 1)) ? '0 : idx + PW'(1);
  endfunction

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: the latched request fields are reset too, because every
      // output must read zero while reset is held.
      state           <= IDLE;
      pointer         <= '0;
      grant_index     <= '0;
      timer           <= '0;
      status          <= RGGEN_OKAY;
      o_req_ack       <= '0;
      o_req_read_data <= '0;
      o_valid         <= 1'b0;
      o_write         <= 1'b0;
      o_address       <= '0;
      o_write_data    <= '0;
      o_strobe        <= '0;
      o_grant         <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples pre-edge values regardless of statement order.
      o_req_ack       <= '0;
      o_req_read_data <= '0;
      status          <= RGGEN_OKAY;
      case (state)
        IDLE: begin
          if (rr_found) begin
            state        <= BUSY;
            grant_index  <= rr_index;
            o_grant      <= rr_grant;
            o_valid      <= 1'b1;
            o_write      <= i_req_write[rr_index];
            o_address    <= i_req_address[rr_index*ADDRESS_WIDTH+:ADDRESS_WIDTH];
            o_write_data <= i_req_write_data[rr_index*BUS_WIDTH+:BUS_WIDTH];
            o_strobe     <= i_req_strobe[rr_index*SW+:SW];
            timer        <= '0;
          end
        end
        BUSY: begin
          if (finish) begin
            o_req_ack       <= o_grant;
            status          <= i_ready ? rggen_status'(i_status) : RGGEN_SLVERR;
            o_req_read_data <= i_ready ? i_read_data : '0;
            state           <= IDLE;
            o_valid         <= 1'b0;
            o_grant         <= '0;
            pointer         <= next_pointer(grant_index);
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
